// File: rtl/ucode_checkpoint_monitor_pkg.sv
// Shared types for the microcode checkpoint monitor: checkpoint modes, FSM states,
// failure causes and the per-entry checkpoint record.
package ucmon_pkg;

    localparam int UC_PC_W   = 12;
    localparam int UC_NCHK   = 32;
    localparam int UC_NFAIL  = 4;
    localparam int UC_CNT_W  = 16;
    localparam int UC_WDOG_W = 24;
    localparam int UC_IDX_W  = $clog2(UC_NCHK);
    localparam int UC_FIDX_W = $clog2(UC_NFAIL);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_REPORT = 2'd1,
        MODE_JUMP   = 2'd2,
        MODE_LOOP   = 2'd3
    } mode_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_PASS = 2'd2;
    localparam state_t ST_FAIL = 2'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'd0,
        CAUSE_FAIL_LABEL = 2'd1,
        CAUSE_WDOG       = 2'd2
    } cause_t;

    typedef struct packed {
        mode_t                 mode;
        logic [UC_PC_W-1:0]    from_pc;
        logic [UC_PC_W-1:0]    to_pc;
        logic [UC_PC_W-1:0]    target;
        logic [UC_CNT_W-1:0]   limit;
    } checkpoint_t;

    // A programmed limit of zero behaves as a single pass.
    function automatic logic [UC_CNT_W-1:0] loop_limit(input logic [UC_CNT_W-1:0] limit);
        return (limit == '0) ? UC_CNT_W'(1) : limit;
    endfunction

endpackage

// File: rtl/ucode_checkpoint_monitor_if.sv
// Retire-stream, configuration and status bundle between control and the monitor.
interface ucode_checkpoint_monitor_if;
    import ucmon_pkg::*;

    logic                   retire;
    logic [UC_PC_W-1:0]     pc_x;
    logic [UC_PC_W-1:0]     pc_f;
    logic                   start;
    logic                   cfg_we;
    logic [UC_IDX_W-1:0]    cfg_idx;
    mode_t                  cfg_mode;
    logic [UC_PC_W-1:0]     cfg_from;
    logic [UC_PC_W-1:0]     cfg_to;
    logic [UC_PC_W-1:0]     cfg_target;
    logic [UC_CNT_W-1:0]    cfg_limit;
    logic                   fail_we;
    logic [UC_FIDX_W-1:0]   fail_idx;
    logic [UC_PC_W:0]       fail_pc;
    logic [UC_PC_W-1:0]     end_pc;
    logic [UC_WDOG_W-1:0]   wdog_limit;

    logic                   redirect;
    logic [UC_PC_W-1:0]     redirect_pc;
    logic                   hit;
    logic [UC_IDX_W-1:0]    hit_idx;
    logic [UC_NCHK-1:0]     hit_mask;
    state_t                 state;
    cause_t                 cause;
    logic [UC_PC_W-1:0]     fail_pc_x;
    logic [UC_WDOG_W-1:0]   retire_cnt;

    modport master (
        output retire, pc_x, pc_f, start, cfg_we, cfg_idx, cfg_mode, cfg_from, cfg_to,
               cfg_target, cfg_limit, fail_we, fail_idx, fail_pc, end_pc, wdog_limit,
        input  redirect, redirect_pc, hit, hit_idx, hit_mask, state, cause, fail_pc_x,
               retire_cnt
    );

    modport slave (
        input  retire, pc_x, pc_f, start, cfg_we, cfg_idx, cfg_mode, cfg_from, cfg_to,
               cfg_target, cfg_limit, fail_we, fail_idx, fail_pc, end_pc, wdog_limit,
        output redirect, redirect_pc, hit, hit_idx, hit_mask, state, cause, fail_pc_x,
               retire_cnt
    );

endinterface

// File: rtl/ucode_checkpoint_monitor_entry.sv
// One checkpoint table slot: stored (from, to) pair, redirect target and loop counter.
module ucmon_entry
    import ucmon_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_we,
    input  checkpoint_t          i_cp,
    input  logic [UC_PC_W-1:0]   i_pc_x,
    input  logic [UC_PC_W-1:0]   i_pc_f,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic                 o_match,
    output logic                 o_loop_done,
    output mode_t                o_mode,
    output logic [UC_PC_W-1:0]   o_target
);

    checkpoint_t            r_cp;
    logic [UC_CNT_W-1:0]    r_cnt;

    assign o_match     = (r_cp.mode != MODE_OFF) && (r_cp.from_pc == i_pc_x) && (r_cp.to_pc == i_pc_f);
    assign o_loop_done = ({1'b0, r_cnt} + (UC_CNT_W+1)'(1)) >= {1'b0, loop_limit(r_cp.limit)};
    assign o_mode      = r_cp.mode;
    assign o_target    = r_cp.target;

    // Entry storage and loop counter; a rewrite restarts the loop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cp  <= '0;
            r_cnt <= '0;
        end else if (i_we) begin
            r_cp  <= i_cp;
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + UC_CNT_W'(1);
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/ucode_checkpoint_monitor.sv
// Retire-stream monitor: fail/end label compare, checkpoint priority resolution,
// run-state FSM, retire watchdog and registered uPC-redirect / hit outputs.
module ucode_checkpoint_monitor
    import ucmon_pkg::*;
#(
    parameter int PC_W   = UC_PC_W,
    parameter int NCHK   = UC_NCHK,
    parameter int NFAIL  = UC_NFAIL,
    parameter int CNT_W  = UC_CNT_W,
    parameter int WDOG_W = UC_WDOG_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    ucode_checkpoint_monitor_if.slave   bus
);

    localparam int IDX_W = $clog2(NCHK);

    state_t             r_state;
    cause_t             r_cause;
    logic [PC_W-1:0]    r_fail_pc_x;
    logic [WDOG_W-1:0]  r_retire_cnt;
    logic [NCHK-1:0]    r_hit_mask;
    logic               r_redirect;
    logic [PC_W-1:0]    r_redirect_pc;
    logic               r_hit;
    logic [IDX_W-1:0]   r_hit_idx;
    logic [NFAIL-1:0]   r_fail_valid;
    logic [PC_W-1:0]    r_fail_pc [NFAIL];

    checkpoint_t        w_wr_cp;
    logic [NCHK-1:0]    w_match, w_loop_done, w_we, w_inc, w_clr, w_sel_onehot;
    mode_t              w_mode   [NCHK];
    logic [PC_W-1:0]    w_target [NCHK];
    logic               w_fail_hit, w_wdog, w_end, w_any, w_eval, w_cp_loop, w_cfg_open;
    logic [IDX_W-1:0]   w_sel;
    mode_t              w_sel_mode;

    assign w_cfg_open = (r_state != ST_RUN);
    assign w_wr_cp    = '{mode: bus.cfg_mode, from_pc: bus.cfg_from, to_pc: bus.cfg_to,
                          target: bus.cfg_target, limit: bus.cfg_limit};

    for (genvar gi = 0; gi < NCHK; gi++) begin : g_entry
        assign w_we[gi] = w_cfg_open && bus.cfg_we && (bus.cfg_idx == IDX_W'(gi));
        ucmon_entry u_entry (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_we        (w_we[gi]),
            .i_cp        (w_wr_cp),
            .i_pc_x      (bus.pc_x),
            .i_pc_f      (bus.pc_f),
            .i_inc       (w_inc[gi]),
            .i_clr       (w_clr[gi]),
            .o_match     (w_match[gi]),
            .o_loop_done (w_loop_done[gi]),
            .o_mode      (w_mode[gi]),
            .o_target    (w_target[gi])
        );
    end

    // Fail-label hit: any valid label equal to the retiring PC.
    always_comb begin
        w_fail_hit = 1'b0;
        for (int k = 0; k < NFAIL; k++) begin
            w_fail_hit = w_fail_hit | (r_fail_valid[k] & (r_fail_pc[k] == bus.pc_x));
        end
    end

    // Lowest-index matching entry wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = NCHK - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                w_any = 1'b1;
                w_sel = IDX_W'(k);
            end else begin
                w_any = w_any;
            end
        end
    end

    assign w_eval       = (r_state == ST_RUN) && bus.retire;
    assign w_wdog       = (bus.wdog_limit != '0) &&
                          (({1'b0, r_retire_cnt} + (WDOG_W+1)'(1)) == {1'b0, bus.wdog_limit});
    assign w_end        = (bus.pc_x == bus.end_pc);
    assign w_sel_mode   = w_mode[w_sel];
    assign w_sel_onehot = NCHK'(1) << w_sel;
    assign w_cp_loop    = w_eval && !w_fail_hit && !w_wdog && !w_end && w_any && (w_sel_mode == MODE_LOOP);
    assign w_inc        = {NCHK{w_cp_loop && !w_loop_done[w_sel]}} & w_sel_onehot;
    assign w_clr        = {NCHK{w_cp_loop &&  w_loop_done[w_sel]}} & w_sel_onehot;

    // Fail-label registers, writable only outside RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fail_valid <= '0;
            for (int k = 0; k < NFAIL; k++) r_fail_pc[k] <= '0;
        end else if (bus.fail_we && w_cfg_open) begin
            r_fail_valid[bus.fail_idx] <= bus.fail_pc[PC_W];
            r_fail_pc[bus.fail_idx]    <= bus.fail_pc[PC_W-1:0];
        end
    end

    // FSM, watchdog count, sticky hit mask and one-cycle redirect/hit pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cause       <= CAUSE_NONE;
            r_fail_pc_x   <= '0;
            r_retire_cnt  <= '0;
            r_hit_mask    <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_hit         <= 1'b0;
            r_hit_idx     <= '0;
        end else begin
            r_redirect <= 1'b0;
            r_hit      <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (bus.retire) begin
                        if (r_retire_cnt != '1) r_retire_cnt <= r_retire_cnt + WDOG_W'(1);
                        if (w_fail_hit) begin
                            r_state     <= ST_FAIL;
                            r_cause     <= CAUSE_FAIL_LABEL;
                            r_fail_pc_x <= bus.pc_x;
                        end else if (w_wdog) begin
                            r_state     <= ST_FAIL;
                            r_cause     <= CAUSE_WDOG;
                            r_fail_pc_x <= bus.pc_x;
                        end else if (w_end) begin
                            r_state <= ST_PASS;
                        end else if (w_any) begin
                            case (w_sel_mode)
                                MODE_REPORT: begin
                                    r_hit             <= 1'b1;
                                    r_hit_idx         <= w_sel;
                                    r_hit_mask[w_sel] <= 1'b1;
                                end
                                MODE_JUMP: begin
                                    r_hit             <= 1'b1;
                                    r_hit_idx         <= w_sel;
                                    r_hit_mask[w_sel] <= 1'b1;
                                    r_redirect        <= 1'b1;
                                    r_redirect_pc     <= w_target[w_sel];
                                end
                                MODE_LOOP: begin
                                    if (w_loop_done[w_sel]) begin
                                        r_hit             <= 1'b1;
                                        r_hit_idx         <= w_sel;
                                        r_hit_mask[w_sel] <= 1'b1;
                                    end else begin
                                        r_redirect    <= 1'b1;
                                        r_redirect_pc <= w_target[w_sel];
                                    end
                                end
                                default: r_hit <= 1'b0;
                            endcase
                        end
                    end
                end
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (bus.start) begin
                        r_state      <= ST_RUN;
                        r_cause      <= CAUSE_NONE;
                        r_retire_cnt <= '0;
                        r_hit_mask   <= '0;
                    end else if (bus.cfg_we) begin
                        r_hit_mask[bus.cfg_idx] <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.redirect    = r_redirect;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.hit         = r_hit;
    assign bus.hit_idx     = r_hit_idx;
    assign bus.hit_mask    = r_hit_mask;
    assign bus.state       = r_state;
    assign bus.cause       = r_cause;
    assign bus.fail_pc_x   = r_fail_pc_x;
    assign bus.retire_cnt  = r_retire_cnt;

endmodule
